// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes instruction and data cache requests onto a single
// ported RAM and returns completion with wait-low handshakes.
// Optional build macro: MEM_PERF_CNT_EN adds icount/dcount completion counters.

package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  // instruction cache side
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  // data cache side
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  // RAM side
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate
`ifdef MEM_PERF_CNT_EN
  ,
  output word_t      icount,
  output word_t      dcount
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISERVE = 2'd1,
    DSERVE = 2'd2
  } arb_state_t;

  arb_state_t state, next_state;
  logic       last_d;
  logic       dreq;
  logic       ram_ack;
  logic       idone;
  logic       ddone;

  assign dreq    = dREN | dWEN;
  assign ram_ack = (ramstate_t'(ramstate) == ACCESS);

  // State register; reset discards any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Remembers which side completed last so a pending instruction fetch
  // wins over data until it has been served once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d <= 1'b0;
    end else if (ddone) begin
      last_d <= 1'b1;
    end else if (idone) begin
      last_d <= 1'b0;
    end
  end

  // Grant decision, RAM drive and wait/load returns.
  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    idone      = 1'b0;
    ddone      = 1'b0;

    unique case (state)
      IDLE: begin
        // data normally wins; right after a data completion a waiting fetch goes first
        if (dreq && !(last_d && iREN)) begin
          next_state = DSERVE;
        end else if (iREN) begin
          next_state = ISERVE;
        end
      end

      ISERVE: begin
        if (!iREN) begin
          // requester withdrew: release the RAM at once, no completion
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_ack) begin
            iwait      = 1'b0;
            iload      = ramload;
            idone      = 1'b1;
            next_state = IDLE;
          end
        end
      end

      DSERVE: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_ack) begin
            dwait      = 1'b0;
            dload      = ramload;
            ddone      = 1'b1;
            next_state = IDLE;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef MEM_PERF_CNT_EN
  // Completion counters, wrapping through zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (idone) icount <= icount + 32'd1;
      if (ddone) dcount <= dcount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a shadow memory and a transaction-level
// latency rule predict each completion; a monitor checks what the DUT returns.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore;
  word_t      ramload = '0;
  ramstate_t  ramstate = FREE;
  logic       iwait, dwait, ramREN, ramWEN;
  word_t      iload, dload, ramaddr, ramstore;
`ifdef MEM_PERF_CNT_EN
  word_t      icount, dcount;
`endif

  mem_arbiter dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef MEM_PERF_CNT_EN
    ,
    .icount   (icount),
    .dcount   (dcount)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit    is_d;
    bit    we;
    word_t addr;
    word_t data;
    int    cyc;
  } exp_t;

  exp_t      sb[$];
  ramstate_t plan[$];
  word_t     ram_mem[word_t];
  word_t     shadow[word_t];
  int        cyc = 0;
  int        n_chk = 0;
  int        n_fail = 0;
  int        n_i_exp = 0;
  int        n_d_exp = 0;

  function automatic word_t initval(word_t a);
    if (a == 32'h40) return 32'h8C220004;
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic word_t shadow_rd(word_t a);
    return shadow.exists(a) ? shadow[a] : initval(a);
  endfunction

  function automatic word_t ram_rd(word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : initval(a);
  endfunction

  function automatic void chk(string name, word_t act, word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic ramstate_t pick_wait();
    case ($urandom_range(0, 2))
      0:       return FREE;
      1:       return BUSY;
      default: return ERROR;
    endcase
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // RAM model: consumes one planned status per enabled cycle, then ACCESS.
  initial forever begin
    @(posedge CLK);
    #2;
    if (ramREN || ramWEN) ramstate = (plan.size() != 0) ? plan.pop_front() : ACCESS;
    else                  ramstate = FREE;
    ramload = (ramstate == ACCESS && ramREN) ? ram_rd(ramaddr) : $urandom();
    @(negedge CLK);
    if (nRST && ramWEN && ramstate == ACCESS) ram_mem[ramaddr] = ramstore;
  end

  // Monitor: invariants every cycle, scoreboard pop on any completion.
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (nRST === 1'b1) begin
      chk("single_wait_low", {31'b0, (iwait === 1'b0 && dwait === 1'b0)}, 0);
      if (iwait) chk("iload_gated", iload, 0);
      if (dwait) chk("dload_gated", dload, 0);
      if (!iwait || !dwait) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: iwait=%b dwait=%b with nothing outstanding (cycle %0d)",
                   iwait, dwait, cyc);
        end else begin
          e = sb.pop_front();
          chk("done_side", {31'b0, iwait}, {31'b0, e.is_d});
          chk("done_cycle", cyc, e.cyc);
          chk("ram_addr", ramaddr, e.addr);
          if (e.we) begin
            chk("ram_wen", {31'b0, ramWEN}, 1);
            chk("ram_store", ramstore, e.data);
          end else begin
            chk("ram_ren", {31'b0, ramREN}, 1);
            chk("load_data", e.is_d ? dload : iload, e.data);
          end
        end
      end
    end
  end

  // Issue one request in the current cycle; completion is due one cycle after
  // the non-ACCESS statuses plus any extra arbitration delay.
  task automatic issue(input bit is_d, input bit we, input word_t a, input word_t d,
                       input int nacc, input ramstate_t fill, input bit rnd, input int extra);
    exp_t e;
    for (int i = 0; i < nacc; i++) plan.push_back(rnd ? pick_wait() : fill);
    plan.push_back(ACCESS);
    e.is_d = is_d;
    e.we   = we;
    e.addr = a;
    e.cyc  = cyc + 1 + nacc + extra;
    if (we) begin
      shadow[a] = d;
      e.data    = d;
    end else begin
      e.data = shadow_rd(a);
    end
    sb.push_back(e);
    if (is_d) begin
      n_d_exp++;
      daddr  = a;
      dstore = d;
      dREN   = !we;
      dWEN   = we;
    end else begin
      n_i_exp++;
      iaddr = a;
      iREN  = 1'b1;
    end
  endtask

  task automatic wait_done(input bit is_d);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge CLK);
      seen = is_d ? !dwait : !iwait;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: wait still high after 64 cycles, required low", is_d ? "data" : "inst");
    end
    @(posedge CLK);
    #1;
    if (is_d) begin
      dREN = 1'b0;
      dWEN = 1'b0;
    end else begin
      iREN = 1'b0;
    end
  endtask

  initial begin
    nRST   = 1'b0;
    iREN   = 1'b1;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    iaddr  = 32'h40;
    daddr  = '0;
    dstore = '0;

    // reset with an instruction request pending
    repeat (2) @(negedge CLK);
    chk("rst_iwait", {31'b0, iwait}, 1);
    chk("rst_dwait", {31'b0, dwait}, 1);
    chk("rst_ramren", {31'b0, ramREN}, 0);
    chk("rst_ramwen", {31'b0, ramWEN}, 0);
    chk("rst_iload", iload, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    @(posedge CLK);
    #1;
    iREN = 1'b0;
    nRST = 1'b1;

    // single instruction fetch, immediate ACCESS
    @(posedge CLK);
    #1;
    issue(0, 0, 32'h40, '0, 0, FREE, 0, 0);
    wait_done(0);

    // collision: data write first, then fetch beats the reasserted data read
    issue(1, 1, 32'h100, 32'hDEADBEEF, 0, FREE, 0, 0);
    issue(0, 0, 32'h40, '0, 0, FREE, 0, 2);
    wait_done(1);
    issue(1, 0, 32'h100, '0, 0, FREE, 0, 2);
    wait_done(0);
    wait_done(1);

    // BUSY stretch, then ERROR retries on a write and on a fetch
    issue(1, 0, 32'h100, '0, 3, BUSY, 0, 0);
    wait_done(1);
    issue(1, 1, 32'h24, 32'h12345678, 2, ERROR, 0, 0);
    wait_done(1);
    issue(0, 0, 32'h24, '0, 2, ERROR, 0, 0);
    wait_done(0);

    // abort: data read withdrawn while served
    plan.delete();
    repeat (3) plan.push_back(BUSY);
    daddr = 32'h80;
    dREN  = 1'b1;
    repeat (2) @(negedge CLK);
    chk("abort_ren_before", {31'b0, ramREN}, 1);
    chk("abort_ramaddr", ramaddr, 32'h80);
    @(posedge CLK);
    #1;
    dREN = 1'b0;
    @(negedge CLK);
    chk("abort_ren_drop", {31'b0, ramREN}, 0);
    chk("abort_dwait", {31'b0, dwait}, 1);
    plan.delete();
    @(posedge CLK);
    #1;
    issue(0, 0, 32'h40, '0, 0, FREE, 0, 0);
    wait_done(0);

    // reset in the middle of a fetch
    repeat (4) plan.push_back(BUSY);
    iaddr = 32'h44;
    iREN  = 1'b1;
    repeat (2) @(negedge CLK);
    chk("pre_rst_ramren", {31'b0, ramREN}, 1);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(negedge CLK);
    chk("midrst_iwait", {31'b0, iwait}, 1);
    chk("midrst_ramren", {31'b0, ramREN}, 0);
    chk("midrst_ramaddr", ramaddr, 0);
    chk("midrst_iload", iload, 0);
    @(posedge CLK);
    #1;
    iREN = 1'b0;
    plan.delete();
    n_i_exp = 0;
    n_d_exp = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // randomized single-requester traffic
    for (int t = 0; t < 80; t++) begin
      bit    is_d = 1'($urandom_range(0, 1));
      bit    we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      word_t a    = 32'($urandom_range(0, 15)) * 32'd4;
      word_t d    = $urandom();
      int    gap  = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge CLK);
        #1;
      end
      issue(is_d, we, a, d, $urandom_range(0, 3), FREE, 1, 0);
      wait_done(is_d);
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
`ifdef MEM_PERF_CNT_EN
    chk("icount", icount, n_i_exp);
    chk("dcount", dcount, n_d_exp);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
